// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and width defaults shared by the multiply/divide unit.
package muldiv_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ITER_CNT_W = $clog2(DATA_WIDTH_DEF);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MADDU = 3'b111;
    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;
endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: conditional two's-complement negate, used for abs on entry and sign fixup on exit.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);
    assign res = neg ? -val : val;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO, single-cycle MTHI/MTLO.
// Define MULDIV_MADD_EN to enable MADD/MADDU accumulation into {hi,lo}.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W = DATA_WIDTH;
    localparam int CW = $clog2(W);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    m;
    logic [W-1:0]    a_orig;
    logic            is_div_q, madd_q, neg_res, neg_rem, bzero;
    logic            is_iter, sgn;
    logic [W-1:0]    a_abs, b_abs, quot_fix, rem_fix;
    logic [2*W-1:0]  prod_fix, mul_step, div_step, mul_base;
    logic [W:0]      sum, r, d;

`ifdef MULDIV_MADD_EN
    assign is_iter = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU};
`else
    assign is_iter = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
`endif
    assign sgn = op inside {OP_MULT, OP_DIV, OP_MADD};

    muldiv_signfix #(.W(W))   u_abs_a (.val(a), .neg(sgn & a[W-1]), .res(a_abs));
    muldiv_signfix #(.W(W))   u_abs_b (.val(b), .neg(sgn & b[W-1]), .res(b_abs));
    muldiv_signfix #(.W(2*W)) u_prod  (.val(acc), .neg(neg_res), .res(prod_fix));
    muldiv_signfix #(.W(W))   u_quot  (.val(acc[W-1:0]), .neg(neg_res), .res(quot_fix));
    muldiv_signfix #(.W(W))   u_rem   (.val(acc[2*W-1:W]), .neg(neg_rem), .res(rem_fix));

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, m} : '0);
        mul_step = {sum, acc[W-1:1]};
        r        = {acc[2*W-1:W], acc[W-1]};
        d        = r - {1'b0, m};
        div_step = {d[W] ? r[W-1:0] : d[W-1:0], acc[W-2:0], ~d[W]};
        mul_base = madd_q ? {hi, lo} : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            cnt         <= '0;
            acc         <= '0;
            m           <= '0;
            a_orig      <= '0;
            is_div_q    <= 1'b0;
            madd_q      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            bzero       <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        if (is_iter) begin
                            state    <= CALC;
                            busy     <= 1'b1;
                            cnt      <= '0;
                            acc      <= {{W{1'b0}}, a_abs};
                            m        <= b_abs;
                            a_orig   <= a;
                            is_div_q <= op inside {OP_DIV, OP_DIVU};
                            madd_q   <= op inside {OP_MADD, OP_MADDU};
                            neg_res  <= sgn & (a[W-1] ^ b[W-1]);
                            neg_rem  <= sgn & a[W-1];
                            bzero    <= b == '0;
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc   <= is_div_q ? div_step : mul_step;
                        cnt   <= cnt + 1'b1;
                        state <= (cnt == CW'(W - 1)) ? FIXUP : CALC;
                    end
                end
                FIXUP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        done        <= 1'b1;
                        div_by_zero <= is_div_q & bzero;
                        if (!is_div_q)
                            {hi, lo} <= prod_fix + mul_base;
                        else if (bzero)
                            {hi, lo} <= {a_orig, {W{1'b1}}};
                        else
                            {hi, lo} <= {rem_fix, quot_fix};
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit; define MULDIV_MADD_EN to cover MADD/MADDU.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;
    int          total = 0;
    int          bad = 0;
    int          seen;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        step();
        start = 1'b0;
    endtask

    // from cycle N+1, advance to cycle N+34 where the result must be visible
    task automatic finish_op(input string tag, input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        for (int k = 0; k < 33; k++) step();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_dbz"}, div_by_zero, edbz);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);

        launch(3'b000, 32'hFFFF_FFFD, 32'd7);
        seen = 0;
        for (int k = 1; k <= 33; k++) begin
            seen += (busy === 1'b1 && done === 1'b0) ? 1 : 0;
            step();
        end
        chk("mult_busy_cycles", seen, 33);
        chk("mult_done", done, 1);
        chk("mult_busy_end", busy, 0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);
        step();
        chk("mult_done_pulse", done, 0);

        launch(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 0; k < 33; k++) step();
        chk("multu_done", done, 1);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        launch(3'b010, 32'hFFFF_FFF9, 32'd2);
        chk("b2b_busy", busy, 1);
        finish_op("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

        launch(3'b011, 32'd100, 32'd0);
        finish_op("divu_zero", 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        step();
        chk("dbz_pulse", div_by_zero, 0);
        launch(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf", 32'h0000_0000, 32'h8000_0000, 1'b0);

        launch(3'b100, 32'h1234_5678, 32'd0);
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_done", done, 0);
        chk("mthi_busy", busy, 0);
        launch(3'b101, 32'hCAFE_0001, 32'd0);
        chk("mtlo_lo", lo, 32'hCAFE_0001);

        launch(3'b001, 32'd6, 32'd7);
        start = 1'b1;
        op = 3'b101;
        a = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) step();
        op = 3'b001;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) step();
        start = 1'b0;
        for (int k = 0; k < 27; k++) step();
        chk("busy_ign_done", done, 1);
        chk("busy_ign_hi", hi, 32'd0);
        chk("busy_ign_lo", lo, 32'd42);

        launch(3'b000, 32'd5, 32'd5);
        for (int k = 0; k < 9; k++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            seen += (done === 1'b1 || busy === 1'b1) ? 1 : 0;
            step();
        end
        chk("flush_quiet", seen, 0);
        chk("flush_hi", hi, 32'd0);
        chk("flush_lo", lo, 32'd42);

        start = 1'b1;
        flush = 1'b1;
        op = 3'b100;
        a = 32'h0000_0055;
        step();
        op = 3'b000;
        step();
        start = 1'b0;
        flush = 1'b0;
        chk("sflush_hi", hi, 32'd0);
        chk("sflush_busy", busy, 0);

        launch(3'b010, 32'd100, 32'd7);
        for (int k = 0; k < 4; k++) step();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_lo", lo, 0);
        chk("arst_done", done, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_busy", busy, 0);

        launch(3'b100, 32'd0, 32'd0);
        launch(3'b101, 32'hFFFF_FFFF, 32'd0);
`ifdef MULDIV_MADD_EN
        launch(3'b111, 32'd1, 32'd1);
        finish_op("maddu", 32'd1, 32'd0, 1'b0);
        launch(3'b110, 32'hFFFF_FFFF, 32'd1);
        finish_op("madd", 32'd0, 32'hFFFF_FFFF, 1'b0);
`else
        launch(3'b111, 32'd1, 32'd1);
        seen = 0;
        for (int k = 0; k < 36; k++) begin
            seen += (busy === 1'b1 || done === 1'b1) ? 1 : 0;
            step();
        end
        chk("maddu_off_quiet", seen, 0);
        chk("maddu_off_hi", hi, 32'd0);
        chk("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers, sitting in EX directly downstream of the register file and consuming its A/B operand outputs. Executes MULT, MULTU, DIV, DIVU as multi-cycle shift-add / restoring-divide sequences, plus single-cycle MTHI/MTLO. The control unit stalls on busy; MFHI/MFLO read the hi/lo outputs directly.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  op request; sampled only while idle
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU
a  input  DATA_WIDTH  rs operand (register file A)
b  input  DATA_WIDTH  rt operand (register file B)
flush  input  1  cancel in-flight op (pipeline flush)
busy  output  1  high while an iterative op is in progress
done  output  1  one-cycle pulse when HI/LO receive an iterative result
div_by_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with b==0
hi  output  DATA_WIDTH  HI register
lo  output  DATA_WIDTH  LO register

Behaviour:
- Clock clk; reset rst is asynchronous and active-high. Reset: state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0. Reset mid-operation aborts immediately; no result is written.
- States: IDLE, CALC, FIXUP.
- IDLE: on start=1, op MULT/MULTU/DIV/DIVU (or MADD/MADDU when enabled): latch |a|, |b| (signed ops) or a, b (unsigned), latch sign bits and op; counter=0; go to CALC. op MTHI/MTLO: write a to hi/lo at that edge, stay IDLE, no done.
- CALC: one iteration per cycle, 32 cycles (counter 0..31). Multiply: shift-add into 64-bit product. Divide: restoring, one quotient bit per cycle into 64-bit {rem,quot}. After counter==31, go to FIXUP.
- FIXUP: sign correction: signed product negated if signs differ; signed quotient negated if signs differ; remainder takes dividend sign. Write hi=product[63:32] / remainder, lo=product[31:0] / quotient. Go to IDLE; done=1 for the following cycle.
- Latency: start sampled at edge ending cycle N -> busy=1 cycles N+1..N+33 -> hi/lo/done valid in cycle N+34, busy=0 then. start during N+34 is accepted (back-to-back).
- Divide by zero: iteration still runs full length (deterministic latency); result forced hi=a (original dividend), lo=all ones; div_by_zero pulses with done.
- Signed overflow: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, no flag.
- start while busy: ignored (no queueing). start with flush in the same IDLE cycle: flush wins, nothing latched.
- flush while busy: next edge -> IDLE, busy=0, hi/lo unchanged, no done.
- Operands a/b are only sampled at the accepting edge; later changes do not affect the result.

Optional Feature:
MULDIV_MADD_EN: when defined, op 110/111 (MADD/MADDU) run the multiply path and FIXUP writes {hi,lo} = {hi,lo} + product (64-bit wrap, signed or unsigned product per op); same latency as MULT. When undefined, ops 110/111 are no-ops: not accepted, busy stays 0, hi/lo unchanged.

Decomposition:
- muldiv_pkg: op encoding constants, state enum, DATA_WIDTH default, ITER_CNT_W = clog2(DATA_WIDTH).
- One sub-module is natural: muldiv_signfix (combinational abs/conditional-negate for operands and results), instantiated for operand entry and for FIXUP.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> at cycle N+34 done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly N+1..N+33.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then DIV a=0xFFFFFFF9 (-7), b=2 back-to-back -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> hi=0x00000064, lo=0xFFFFFFFF, div_by_zero and done pulse together; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 in IDLE -> hi=0x12345678 next cycle, done stays 0; MTLO during busy ignored, and start with new operands during busy does not alter result.
- Start MULT, assert flush at cycle N+10 -> busy=0 at N+11, hi/lo keep previous values, no done; assert rst at N+5 of a DIV -> all outputs 0 immediately.
- With MULDIV_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 -> hi=1, lo=0; without macro same stimulus -> busy never rises, hi/lo unchanged.
